// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles UART bytes into validated command frames.
// Frame: SOF | CMD | LEN | PAYLOAD[LEN] | XOR(CMD,LEN,PAYLOAD).
module uart_frame_parser #(
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int          MAX_LEN = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [7:0]  LED_CMD = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ack,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [3:0]  cmd_len,
    output logic [63:0] payload,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  led,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    state_t      state;
    state_t      state_n;
    logic        stb_d;
    logic [7:0]  chk_q;
    logic [7:0]  cmd_q;
    logic [3:0]  len_q;
    logic [2:0]  idx_q;
    logic [63:0] buf_q;
    logic [15:0] tcnt;
    logic        consume;
    logic        len_ok;
    logic        tmo;
    logic        go_ok;
    logic        go_err;
    logic [1:0]  err_n;

    // rx_data is valid the cycle after rx_ack, so the delayed strobe marks it
    assign consume = stb_d;
    assign len_ok  = rx_data <= MAX_B;
    assign tmo     = (state != S_IDLE) && !consume &&
                     (tcnt == TIMEOUT - 16'd1);
    assign busy    = state != S_IDLE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state and frame verdict decode
    always_comb begin
        state_n = state;
        go_ok   = 1'b0;
        go_err  = 1'b0;
        err_n   = 2'd0;
        unique case (state)
            S_IDLE: begin
                if (consume && rx_data == SOF) state_n = S_CMD;
            end
            S_CMD: begin
                if (consume) state_n = S_LEN;
            end
            S_LEN: begin
                if (consume) begin
                    if (rx_data == 8'd0) begin
                        state_n = S_CHK;
                    end else if (len_ok) begin
                        state_n = S_PAYLOAD;
                    end else begin
                        state_n = S_IDLE;
                        go_err  = 1'b1;
                        err_n   = 2'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (consume && ({1'b0, idx_q} == len_q - 4'd1))
                    state_n = S_CHK;
            end
            S_CHK: begin
                if (consume) begin
                    state_n = S_IDLE;
                    if (rx_data == chk_q) begin
                        go_ok = 1'b1;
                    end else begin
                        go_err = 1'b1;
                        err_n  = 2'd2;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // tmo excludes consume cycles, so a consumed byte always wins
        if (tmo) begin
            state_n = S_IDLE;
            go_err  = 1'b1;
            err_n   = 2'd3;
        end
    end

    // Byte strobe delay and inter-byte idle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_d <= 1'b0;
            tcnt  <= 16'd0;
        end else begin
            stb_d <= rx_ack;
            if (consume || state_n == S_IDLE) tcnt <= 16'd0;
            else                              tcnt <= tcnt + 16'd1;
        end
    end

    // Frame field capture and checksum accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= 8'd0;
            cmd_q <= 8'd0;
            len_q <= 4'd0;
            idx_q <= 3'd0;
            buf_q <= 64'd0;
        end else if (consume) begin
            unique case (state)
                S_IDLE: begin
                    if (rx_data == SOF) begin
                        chk_q <= 8'd0;
                        len_q <= 4'd0;
                        idx_q <= 3'd0;
                        buf_q <= 64'd0;
                    end
                end
                S_CMD: begin
                    cmd_q <= rx_data;
                    chk_q <= chk_q ^ rx_data;
                end
                S_LEN: begin
                    if (len_ok) begin
                        len_q <= rx_data[3:0];
                        idx_q <= 3'd0;
                        chk_q <= chk_q ^ rx_data;
                    end
                end
                S_PAYLOAD: begin
                    buf_q[{idx_q, 3'b000} +: 8] <= rx_data;
                    chk_q <= chk_q ^ rx_data;
                    idx_q <= idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered command outputs, strobes and LED register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            cmd       <= 8'd0;
            cmd_len   <= 4'd0;
            payload   <= 64'd0;
            led       <= 8'd0;
        end else begin
            cmd_valid <= go_ok;
            frame_err <= go_err;
            if (go_err) err_code <= err_n;
            if (go_ok) begin
                cmd     <= cmd_q;
                cmd_len <= len_q;
                payload <= buf_q;
                if (cmd_q == LED_CMD && len_q != 4'd0)
                    led <= buf_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and random frames against a
// frame-scanning reference model of the parser.
module tb_uart_frame_parser;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         MAX_LEN = 8;
    localparam int         TMO     = 20;
    localparam logic [7:0] LED_CMD = 8'h01;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ack = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [3:0]  cmd_len;
    logic [63:0] payload;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  led;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_cmd  = 8'd0;
    logic [3:0]  m_len  = 4'd0;
    logic [63:0] m_pl   = 64'd0;
    logic [7:0]  m_led  = 8'd0;
    logic [1:0]  m_code = 2'd0;
    logic        m_busy = 1'b0;

    uart_frame_parser #(
        .SOF(SOF),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT(16'(TMO)),
        .LED_CMD(LED_CMD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_ack(rx_ack),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_len(cmd_len),
        .payload(payload),
        .frame_err(frame_err),
        .err_code(err_code),
        .led(led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic v, input logic e);
        chk("cmd_valid", 64'(cmd_valid), 64'(v));
        chk("frame_err", 64'(frame_err), 64'(e));
        chk("busy",      64'(busy),      64'(m_busy));
        chk("cmd",       64'(cmd),       64'(m_cmd));
        chk("cmd_len",   64'(cmd_len),   64'(m_len));
        chk("payload",   payload,        m_pl);
        chk("led",       64'(led),       64'(m_led));
        chk("err_code",  64'(err_code),  64'(m_code));
    endtask

    // Scan the byte list frame by frame, then replay it cycle by cycle
    task automatic run_stream(input bq_t bq, input int gmax,
                              input bit allow_tmo);
        int n;
        int i;
        int c8;
        int l8;
        int f;
        int kv;
        int last_c;
        int tmo_c;
        int end_c;
        logic [7:0] x;
        logic [63:0] pl;
        logic v;
        logic e;
        int t[];
        int ev[];
        int code[];
        bit bsy[];
        logic [7:0] ecmd[];
        logic [3:0] elen[];
        logic [63:0] epl[];
        n = bq.size();
        t = new[n];
        ev = new[n];
        code = new[n];
        bsy = new[n];
        ecmd = new[n];
        elen = new[n];
        epl = new[n];
        for (int k = 0; k < n; k++) begin
            ev[k] = 0; code[k] = 0; bsy[k] = 0;
            ecmd[k] = 0; elen[k] = 0; epl[k] = 0;
            t[k] = (k == 0) ? 0 : t[k-1] + int'($urandom_range(1, gmax));
        end
        i = 0;
        while (i < n) begin
            if (bq[i] != SOF) begin
                i++;
                continue;
            end
            bsy[i] = 1;
            if (i + 2 >= n) begin
                for (int j = i + 1; j < n; j++) bsy[j] = 1;
                break;
            end
            c8 = int'(bq[i+1]);
            l8 = int'(bq[i+2]);
            bsy[i+1] = 1;
            if (l8 > MAX_LEN) begin
                ev[i+2] = 2;
                code[i+2] = 1;
                i += 3;
                continue;
            end
            bsy[i+2] = 1;
            if (i + 3 + l8 >= n) begin
                for (int j = i + 3; j < n; j++) bsy[j] = 1;
                break;
            end
            x = 8'(c8) ^ 8'(l8);
            pl = 64'd0;
            for (int p = 0; p < l8; p++) begin
                pl[p*8 +: 8] = bq[i+3+p];
                x ^= bq[i+3+p];
                bsy[i+3+p] = 1;
            end
            f = i + 3 + l8;
            if (bq[f] == x) begin
                ev[f] = 1;
                ecmd[f] = 8'(c8);
                elen[f] = 4'(l8);
                epl[f] = pl;
            end else begin
                ev[f] = 2;
                code[f] = 2;
            end
            i = f + 1;
        end
        last_c = t[n-1] + 2;
        tmo_c = (allow_tmo && bsy[n-1]) ? t[n-1] + 2 + TMO : -1;
        end_c = ((tmo_c >= 0) ? tmo_c : last_c) + 1;
        kv = 0;
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            v = 1'b0;
            e = 1'b0;
            if (kv < n && c == t[kv] + 2) begin
                m_busy = bsy[kv];
                if (ev[kv] == 1) begin
                    v = 1'b1;
                    m_cmd = ecmd[kv];
                    m_len = elen[kv];
                    m_pl = epl[kv];
                    if (ecmd[kv] == LED_CMD && elen[kv] != 0)
                        m_led = epl[kv][7:0];
                end
                if (ev[kv] == 2) begin
                    e = 1'b1;
                    m_code = 2'(code[kv]);
                end
                kv++;
            end
            if (c == tmo_c) begin
                e = 1'b1;
                m_code = 2'd3;
                m_busy = 1'b0;
            end
            check_all(v, e);
            rx_ack = 1'b0;
            rx_data = 8'($urandom);
            for (int k = 0; k < n; k++) begin
                if (t[k] == c) rx_ack = 1'b1;
                if (t[k] + 1 == c) rx_data = bq[k];
            end
        end
        rx_ack = 1'b0;
    endtask

    initial begin
        bq_t q;
        logic [7:0] b;
        logic [7:0] x;
        int len;

        repeat (3) @(negedge clk);
        check_all(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_all(1'b0, 1'b0);

        q = {8'hA5, 8'h01, 8'h01, 8'h3C, 8'h3C};
        run_stream(q, 1, 1'b0);

        q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h21};
        run_stream(q, 3, 1'b0);

        q = {8'hA5, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h00};
        run_stream(q, 2, 1'b0);

        q = {8'hA5, 8'h10, 8'h09, 8'h11, 8'h22,
             8'hA5, 8'h10, 8'h00, 8'h10};
        run_stream(q, 2, 1'b0);

        q = {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h02,
             8'h7E, 8'h81, 8'hFC};
        run_stream(q, 1, 1'b0);

        q = {8'hA5, 8'h01, 8'h00, 8'h01};
        run_stream(q, 1, 1'b0);

        q = {};
        for (int fr = 0; fr < 30; fr++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                q.push_back((b == SOF) ? 8'h00 : b);
            end
            q.push_back(SOF);
            b = ($urandom_range(0, 2) == 0) ? LED_CMD : 8'($urandom);
            q.push_back(b);
            x = b;
            len = int'($urandom_range(0, 10));
            q.push_back(8'(len));
            x ^= 8'(len);
            for (int p = 0; p < len; p++) begin
                b = 8'($urandom);
                q.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            q.push_back(x);
        end
        run_stream(q, 3, 1'b1);

        q = {8'hA5, 8'h20};
        run_stream(q, 1, 1'b1);

        q = {8'hA5, 8'h10, 8'h03, 8'h11};
        run_stream(q, 1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_cmd = 8'd0;
        m_len = 4'd0;
        m_pl = 64'd0;
        m_led = 8'd0;
        m_code = 2'd0;
        m_busy = 1'b0;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        q = {8'hA5, 8'h01, 8'h01, 8'h55, 8'h55};
        run_stream(q, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
